// File: rtl/mod_red_pipe.sv
// Four-stage Barrett modular reducer: out_r = in_x mod q for a 2K-bit product.
// The whole pipeline advances as one unit under a single ready/valid handshake.
module mod_red_pipe #(
    parameter int unsigned K = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*K-1:0] in_x,
    input  logic [K-1:0]   q,
    input  logic [K:0]     mu,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [K-1:0]   out_r,
    output logic           busy
);

    localparam int unsigned PW = 2 * K + 2;

    logic           adv;

    logic           v1_q, v1_d;
    logic [2*K-1:0] x1_q, x1_d;
    logic [PW-1:0]  t1_q, t1_d;

    logic           v2_q, v2_d;
    logic [2*K-1:0] x2_q, x2_d;
    logic [PW-1:0]  t2_q, t2_d;

    logic           v3_q, v3_d;
    logic [K+1:0]   r3_q, r3_d;

    logic           out_valid_q, out_valid_d;
    logic [K-1:0]   out_r_q, out_r_d;

    logic [K+1:0]   q_ext;
    logic [K+1:0]   r_a;
    logic [K+1:0]   r_b;

    always_comb begin
        adv = !out_valid_q || out_ready;

        // r entering S4 is below 3q, so two conditional subtractions suffice
        q_ext = (K+2)'(q);
        r_a   = (r3_q >= q_ext) ? (r3_q - q_ext) : r3_q;
        r_b   = (r_a >= q_ext) ? (r_a - q_ext) : r_a;

        v1_d        = v1_q;
        x1_d        = x1_q;
        t1_d        = t1_q;
        v2_d        = v2_q;
        x2_d        = x2_q;
        t2_d        = t2_q;
        v3_d        = v3_q;
        r3_d        = r3_q;
        out_valid_d = out_valid_q;
        out_r_d     = out_r_q;

        if (adv) begin
            v1_d        = in_valid;
            x1_d        = in_x;
            t1_d        = PW'(in_x >> (K - 1)) * PW'(mu);

            v2_d        = v1_q;
            x2_d        = x1_q;
            t2_d        = PW'(t1_q >> (K + 1)) * PW'(q);

            // True difference is below 3q < 2^(K+2), so the low K+2 bits are exact
            v3_d        = v2_q;
            r3_d        = (K+2)'(x2_q) - (K+2)'(t2_q);

            out_valid_d = v3_q;
            out_r_d     = K'(r_b);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1_q        <= 1'b0;
            x1_q        <= '0;
            t1_q        <= '0;
            v2_q        <= 1'b0;
            x2_q        <= '0;
            t2_q        <= '0;
            v3_q        <= 1'b0;
            r3_q        <= '0;
            out_valid_q <= 1'b0;
            out_r_q     <= '0;
        end else begin
            v1_q        <= v1_d;
            x1_q        <= x1_d;
            t1_q        <= t1_d;
            v2_q        <= v2_d;
            x2_q        <= x2_d;
            t2_q        <= t2_d;
            v3_q        <= v3_d;
            r3_q        <= r3_d;
            out_valid_q <= out_valid_d;
            out_r_q     <= out_r_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_r     = out_r_q;
    assign busy      = v1_q | v2_q | v3_q | out_valid_q;

endmodule

// File: tb/tb_mod_red_pipe.sv
// Bench for mod_red_pipe (K=13, q=7681): queue-based reference model of in_x mod q
// checked on every output transfer, plus directed vectors with literal expectations.
module tb_mod_red_pipe;

    localparam int unsigned K  = 13;
    localparam longint unsigned QV = 7681;
    localparam int unsigned NRAND = 3000;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [2*K-1:0] in_x = '0;
    logic [K-1:0]   q = 13'd7681;
    logic [K:0]     mu = 14'd8736;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [K-1:0]   out_r;
    logic           busy;

    mod_red_pipe #(.K(K)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .q         (q),
        .mu        (mu),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int              n_vec = 0;
    int              n_err = 0;
    int              n_pop = 0;
    longint unsigned exp_q[$];
    logic            hold_chk = 1'b0;
    logic [K-1:0]    held_r = '0;

    logic [2*K-1:0]  b2b_x [4] = '{26'd0, 26'd7681, 26'd58990080, 26'd58990079};
    longint unsigned b2b_e [4] = '{0, 0, 0, 7680};
    logic [2*K-1:0]  st_x  [5] = '{26'd100, 26'd7682, 26'd20000, 26'd12345678, 26'd58990079};

    task automatic check(input string name, input longint unsigned act,
                         input longint unsigned exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: every accepted in_x must come out, in order, as in_x mod q.
    always @(negedge clk) begin
        longint unsigned e;
        if (!reset) begin
            exp_q.delete();
            hold_chk = 1'b0;
            check("rst_out_valid", out_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_in_ready", in_ready, 1);
        end else begin
            check("in_ready", in_ready, (!out_valid || out_ready) ? 1 : 0);
            check("busy", busy, (exp_q.size() != 0) ? 1 : 0);
            if (hold_chk) begin
                check("stall_valid", out_valid, 1);
                check("stall_r", out_r, held_r);
            end
            hold_chk = out_valid && !out_ready;
            held_r   = out_r;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_output: got %0d, expected no output", out_r);
                end else begin
                    e = exp_q.pop_front();
                    n_pop++;
                    check("result", out_r, e);
                end
            end
            if (in_valid && in_ready) exp_q.push_back(longint'(in_x) % QV);
        end
    end

    initial begin
        int   sent;
        int   pop0;
        logic acc;

        // Reset with a live input that must not be taken
        in_valid = 1'b1;
        in_x     = 26'd999;
        repeat (3) step();
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_out_r", out_r, 0);
        check("reset_in_ready", in_ready, 1);

        // Single item: latency of exactly four edges
        reset = 1'b1;
        in_x  = 26'd12345678;
        step();
        in_valid = 1'b0;
        check("lat_e1", out_valid, 0);
        step();
        check("lat_e2", out_valid, 0);
        step();
        check("lat_e3", out_valid, 0);
        step();
        check("lat_e4_valid", out_valid, 1);
        check("lat_e4_r", out_r, 2311);
        step();

        // Back-to-back boundary values
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_x     = b2b_x[i];
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("b2b_valid", out_valid, 1);
            check("b2b_r", out_r, b2b_e[i]);
            step();
        end
        repeat (2) step();

        // Downstream stall for six cycles while feeding five items
        sent = 0;
        for (int c = 0; c < 20; c++) begin
            out_ready = (c >= 6);
            if (sent < 5) begin
                in_valid = 1'b1;
                in_x     = st_x[sent];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            if (c == 4 || c == 5) begin
                check("stall_in_ready", in_ready, 0);
                check("stall_head_r", out_r, 100);
            end
            @(posedge clk);
            #1;
            if (acc) sent++;
        end
        in_valid = 1'b0;
        check("stall_sent", sent, 5);

        // Reset with items in flight
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_x     = 26'(1000 + i * 50000);
            step();
        end
        in_valid = 1'b0;
        step();
        check("mid_pre_valid", out_valid, 1);
        check("mid_pre_busy", busy, 1);
        reset = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("post_rst_quiet", out_valid, 0);
        end

        // Random traffic with random back-pressure
        pop0 = n_pop;
        sent = 0;
        for (int c = 0; c < 40000 && sent < NRAND; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_x      = 26'($urandom());
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) sent++;
        end
        check("rand_sent", sent, NRAND);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) step();
        check("rand_out_count", n_pop - pop0, NRAND);
        check("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
